// File: rtl/pcs_pkg.sv
// Shared types and constants for the PCS transmit framer.
// Holds the framer state encoding, the fixed header bytes and the CRC-16 helper.
package pcs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PREAMBLE = 4'd1,
    ST_SFD      = 4'd2,
    ST_LEN_HI   = 4'd3,
    ST_LEN_LO   = 4'd4,
    ST_PAYLOAD  = 4'd5,
    ST_CRC_HI   = 4'd6,
    ST_CRC_LO   = 4'd7,
    ST_TAIL     = 4'd8,
    ST_GAP      = 4'd9,
    ST_DRAIN    = 4'd10
  } pcs_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_INIT    = 16'hFFFF;

  // CRC-16/CCITT-FALSE advanced by one whole byte, MSB first.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/pcs_tx_out_reg.sv
// One-byte valid/ready output slot. A new byte may load whenever the slot is
// empty or its current byte is being taken this cycle (o_free).
module pcs_tx_out_reg
  import pcs_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_rdy,
  output logic       o_val,
  output logic [7:0] o_data,
  output logic       o_free
);

  logic       val_r;
  logic [7:0] data_r;

  assign o_free = !val_r || i_rdy;
  assign o_val  = val_r;
  assign o_data = data_r;

  // Slot register: load when free, otherwise clear valid once the byte is taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      val_r  <= 1'b0;
      data_r <= 8'h00;
    end else if (i_load && o_free) begin
      val_r  <= 1'b1;
      data_r <= i_data;
    end else if (i_rdy) begin
      val_r  <= 1'b0;
    end else begin
      val_r  <= val_r;
    end
  end

endmodule

// File: rtl/pcs_tx_framer.sv
// PCS transmit framer: wraps the ARI byte stream as preamble, SFD, length,
// payload and CRC-16, with back-pressure reaching upstream via a withheld ack.
module pcs_tx_framer
  import pcs_pkg::*;
#(
  parameter int P_PREAMBLE_LEN = 4,
  parameter int P_GAP_LEN      = 8,
  parameter int P_MAX_LEN      = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ari_val,
  input  logic        i_ari_sof,
  input  logic        i_ari_eof,
  input  logic [1:0]  i_ari_be,
  input  logic [7:0]  i_ari_data,
  output logic        o_ari_ack,
  input  logic [14:0] i_ari_frame_len,
  input  logic        i_ari_frame_len_val,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_val,
  input  logic        i_tx_rdy,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err
);

  pcs_state_e  state_r, state_s;
  logic [14:0] len_r, len_s;
  logic [14:0] pay_cnt_r, pay_cnt_s;
  logic [3:0]  pre_cnt_r, pre_cnt_s;
  logic [7:0]  gap_cnt_r, gap_cnt_s;
  logic [15:0] crc_r, crc_s;
  logic        err_r, err_s;
  logic        load_s;
  logic [7:0]  load_data_s;
  logic        ack_s;
  logic        done_s;
  logic        free_s;
  logic        pay_last_s;
  logic        len_bad_s;
  logic        unused_s;

  assign unused_s   = ^i_ari_be;
  assign pay_last_s = (pay_cnt_r + 15'd1) == len_r;
  assign len_bad_s  = (i_ari_frame_len == 15'd0) ||
                      ({17'd0, i_ari_frame_len} > 32'(P_MAX_LEN));

  pcs_tx_out_reg u_out_reg (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (load_s),
    .i_data (load_data_s),
    .i_rdy  (i_tx_rdy),
    .o_val  (o_tx_val),
    .o_data (o_tx_data),
    .o_free (free_s)
  );

  // Next-state, slot load and handshake decode; states name the next byte to load.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    pay_cnt_s   = pay_cnt_r;
    pre_cnt_s   = pre_cnt_r;
    gap_cnt_s   = gap_cnt_r;
    crc_s       = crc_r;
    err_s       = 1'b0;
    load_s      = 1'b0;
    load_data_s = 8'h00;
    ack_s       = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_ari_val && i_ari_sof && i_ari_frame_len_val && free_s) begin
          if (len_bad_s) begin
            err_s   = 1'b1;
            state_s = ST_DRAIN;
          end else begin
            len_s       = i_ari_frame_len;
            pay_cnt_s   = 15'd0;
            crc_s       = CRC16_INIT;
            load_s      = 1'b1;
            load_data_s = PREAMBLE_BYTE;
            pre_cnt_s   = 4'd1;
            state_s     = (P_PREAMBLE_LEN == 1) ? ST_SFD : ST_PREAMBLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = PREAMBLE_BYTE;
          pre_cnt_s   = pre_cnt_r + 4'd1;
          state_s     = (pre_cnt_r == 4'(P_PREAMBLE_LEN - 1)) ? ST_SFD : ST_PREAMBLE;
        end else begin
          state_s = ST_PREAMBLE;
        end
      end
      ST_SFD: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = SFD_BYTE;
          state_s     = ST_LEN_HI;
        end else begin
          state_s = ST_SFD;
        end
      end
      ST_LEN_HI: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = {1'b0, len_r[14:8]};
          state_s     = ST_LEN_LO;
        end else begin
          state_s = ST_LEN_HI;
        end
      end
      ST_LEN_LO: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = len_r[7:0];
          state_s     = ST_PAYLOAD;
        end else begin
          state_s = ST_LEN_LO;
        end
      end
      ST_PAYLOAD: begin
        if (i_ari_val && free_s) begin
          load_s      = 1'b1;
          load_data_s = i_ari_data;
          ack_s       = 1'b1;
          crc_s       = crc16_ccitt_byte(crc_r, i_ari_data);
          pay_cnt_s   = pay_cnt_r + 15'd1;
          // eof must mark exactly the len-th byte; the count still governs the frame.
          err_s       = pay_last_s ? !i_ari_eof : i_ari_eof;
          state_s     = pay_last_s ? ST_CRC_HI : ST_PAYLOAD;
        end else begin
          state_s = ST_PAYLOAD;
        end
      end
      ST_CRC_HI: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = crc_r[15:8];
          state_s     = ST_CRC_LO;
        end else begin
          state_s = ST_CRC_HI;
        end
      end
      ST_CRC_LO: begin
        if (free_s) begin
          load_s      = 1'b1;
          load_data_s = crc_r[7:0];
          state_s     = ST_TAIL;
        end else begin
          state_s = ST_CRC_LO;
        end
      end
      ST_TAIL: begin
        if (o_tx_val && i_tx_rdy) begin
          done_s    = 1'b1;
          gap_cnt_s = 8'd0;
          state_s   = (P_GAP_LEN == 0) ? ST_IDLE : ST_GAP;
        end else begin
          state_s = ST_TAIL;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 8'(P_GAP_LEN - 1)) begin
          state_s = ST_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 8'd1;
        end
      end
      ST_DRAIN: begin
        ack_s = i_ari_val;
        if (i_ari_val && i_ari_eof) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control and CRC registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      len_r     <= 15'd0;
      pay_cnt_r <= 15'd0;
      pre_cnt_r <= 4'd0;
      gap_cnt_r <= 8'd0;
      crc_r     <= CRC16_INIT;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      len_r     <= len_s;
      pay_cnt_r <= pay_cnt_s;
      pre_cnt_r <= pre_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      crc_r     <= crc_s;
      err_r     <= err_s;
    end
  end

  assign o_ari_ack    = ack_s;
  assign o_frame_done = done_s;
  assign o_err        = err_r;
  assign o_busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_pcs_tx_framer.sv
// Self-checking bench for pcs_tx_framer: table-driven frames plus drain and
// reset sequences, checked against a byte/bit-level model of the wire format.
module tb_pcs_tx_framer;
  localparam int PRE  = 4;
  localparam int GAP  = 8;
  localparam int MAXL = 1024;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int len; int rdy_mode; int val_mode; int pat; int early_eof; int exp_errs; int exp_crc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_ari_val, i_ari_sof, i_ari_eof, i_ari_frame_len_val, i_tx_rdy;
  logic [1:0]  i_ari_be;
  logic [7:0]  i_ari_data;
  logic [14:0] i_ari_frame_len;
  logic        o_ari_ack, o_tx_val, o_busy, o_frame_done, o_err;
  logic [7:0]  o_tx_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pcs_tx_framer #(.P_PREAMBLE_LEN(PRE), .P_GAP_LEN(GAP), .P_MAX_LEN(MAXL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ari_val(i_ari_val), .i_ari_sof(i_ari_sof), .i_ari_eof(i_ari_eof), .i_ari_be(i_ari_be),
    .i_ari_data(i_ari_data), .o_ari_ack(o_ari_ack),
    .i_ari_frame_len(i_ari_frame_len), .i_ari_frame_len_val(i_ari_frame_len_val),
    .o_tx_data(o_tx_data), .o_tx_val(o_tx_val), .i_tx_rdy(i_tx_rdy),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-serial CRC-16/CCITT-FALSE over the payload.
  function automatic logic [15:0] model_crc(input bq_t d);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ d[i][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic bq_t model_wire(input bq_t p);
    bq_t         w;
    logic [15:0] l, c;
    for (int i = 0; i < PRE; i++) w.push_back(8'h55);
    w.push_back(8'hD5);
    l = 16'(p.size());
    w.push_back(l[15:8]);
    w.push_back(l[7:0]);
    foreach (p[i]) w.push_back(p[i]);
    c = model_crc(p);
    w.push_back(c[15:8]);
    w.push_back(c[7:0]);
    return w;
  endfunction

  task automatic drive_idle();
    i_ari_val = 1'b0; i_ari_sof = 1'b0; i_ari_eof = 1'b0; i_ari_be = 2'd0;
    i_ari_data = 8'h00; i_ari_frame_len = 15'd0; i_ari_frame_len_val = 1'b0; i_tx_rdy = 1'b1;
  endtask

  task automatic run_frame(input string tag, input vec_t v, input int abort_at);
    bq_t  pay, exp_w, got;
    int   idx, acks, errs, dones, cyc, first_val, first_ack, gap_busy, bad_bytes;
    bit   bad_ack, bad_stall, bad_err, timeout, done_seen, aborted;
    logic rdy_now, val_now, prev_stall, exp_err_next;
    logic [7:0]  prev_data;
    logic [15:0] crc_got;
    for (int i = 0; i < v.len; i++) begin
      if (v.pat == 0)      pay.push_back(8'(49 + i));
      else if (v.pat == 1) pay.push_back(8'(i));
      else                 pay.push_back(8'($urandom));
    end
    exp_w = model_wire(pay);
    idx = 0; acks = 0; errs = 0; dones = 0; cyc = 0; first_val = -1; first_ack = -1; gap_busy = 0;
    bad_ack = 0; bad_stall = 0; bad_err = 0; timeout = 1; done_seen = 0; aborted = 0;
    prev_stall = 1'b0; prev_data = 8'h00; exp_err_next = 1'b0;
    while (cyc < 5000) begin
      case (v.rdy_mode)
        0:       rdy_now = 1'b1;
        1:       rdy_now = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy_now = ($urandom_range(0, 2) != 0);
      endcase
      if (idx >= v.len)                     val_now = 1'b0;
      else if (idx == 0 || v.val_mode == 0) val_now = 1'b1;
      else if (v.val_mode == 1)             val_now = (cyc % 3 != 2);
      else                                  val_now = ($urandom_range(0, 3) != 0);
      i_ari_val = val_now;
      i_ari_sof = (idx == 0);
      i_ari_eof = (idx == v.len - 1) || (idx == v.early_eof);
      i_ari_data = (idx < v.len) ? pay[idx] : 8'h00;
      i_ari_frame_len = v.len[14:0];
      i_ari_frame_len_val = 1'b1;
      i_ari_be = 2'($urandom);
      i_tx_rdy = rdy_now;
      @(negedge clk);
      if (o_err !== exp_err_next) bad_err = 1;
      if (o_err === 1'b1) errs++;
      exp_err_next = 1'b0;
      if (o_ari_ack === 1'b1) begin
        if (!i_ari_val || (o_tx_val && !i_tx_rdy)) bad_ack = 1;
        if (first_ack < 0) first_ack = cyc;
        if (i_ari_eof != (idx == v.len - 1)) exp_err_next = 1'b1;
        acks++;
        idx++;
      end
      if (o_tx_val === 1'b1 && first_val < 0) first_val = cyc;
      if (prev_stall && (o_tx_val !== 1'b1 || o_tx_data !== prev_data)) bad_stall = 1;
      prev_stall = o_tx_val && !i_tx_rdy;
      prev_data  = o_tx_data;
      if (o_tx_val === 1'b1 && i_tx_rdy) got.push_back(o_tx_data);
      if (o_frame_done === 1'b1) dones++;
      if (done_seen) begin
        if (o_busy === 1'b1) gap_busy++;
        else begin timeout = 0; break; end
      end
      if (o_frame_done === 1'b1) done_seen = 1;
      if (abort_at >= 0 && acks == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_tx_val"}, o_tx_val, 0);
        check({tag, "_rst_tx_data"}, o_tx_data, 0);
        check({tag, "_rst_ack"}, o_ari_ack, 0);
        check({tag, "_rst_busy"}, o_busy, 0);
        check({tag, "_rst_done"}, o_frame_done, 0);
        check({tag, "_rst_err"}, o_err, 0);
        aborted = 1; timeout = 0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (timeout) check({tag, "_timeout"}, 1, 0);
    if (!aborted) begin
      bad_bytes = 0;
      foreach (got[i]) if (i < exp_w.size() && got[i] !== exp_w[i]) bad_bytes++;
      check({tag, "_nbytes"}, got.size(), exp_w.size());
      check({tag, "_bytes_bad"}, bad_bytes, 0);
      check({tag, "_acks"}, acks, v.len);
      check({tag, "_done"}, dones, 1);
      check({tag, "_errs"}, errs, v.exp_errs);
      check({tag, "_err_timing"}, bad_err, 0);
      check({tag, "_ack_rule"}, bad_ack, 0);
      check({tag, "_stall_hold"}, bad_stall, 0);
      check({tag, "_gap"}, gap_busy, GAP);
      check({tag, "_first_val"}, first_val, 1);
      if (v.rdy_mode == 0 && v.val_mode == 0) check({tag, "_first_ack"}, first_ack, PRE + 3);
      if (v.exp_crc >= 0 && got.size() >= 2) begin
        crc_got = {got[got.size() - 2], got[got.size() - 1]};
        check({tag, "_crc_const"}, crc_got, v.exp_crc);
      end
    end
  endtask

  task automatic run_drain(input string tag, input int len, input int nbytes);
    int idx, acks, errs, txv, cyc, tail;
    bit bad_ack;
    idx = 0; acks = 0; errs = 0; txv = 0; cyc = 0; tail = 0; bad_ack = 0;
    while (cyc < 2000 && tail < 3) begin
      i_ari_val = (idx < nbytes) && ((idx == 0) || (cyc % 4 != 3));
      i_ari_sof = (idx == 0);
      i_ari_eof = (idx == nbytes - 1);
      i_ari_data = 8'($urandom);
      i_ari_frame_len = len[14:0];
      i_ari_frame_len_val = 1'b1;
      i_tx_rdy = 1'($urandom);
      @(negedge clk);
      if (o_ari_ack === 1'b1) begin
        if (!i_ari_val) bad_ack = 1;
        acks++;
        idx++;
      end
      if (o_err === 1'b1) errs++;
      if (o_tx_val === 1'b1) txv++;
      if (idx >= nbytes) tail++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_timeout"}, (tail < 3), 0);
    check({tag, "_errs"}, errs, 1);
    check({tag, "_acks"}, acks, nbytes);
    check({tag, "_ack_rule"}, bad_ack, 0);
    check({tag, "_tx_val"}, txv, 0);
    check({tag, "_idle"}, o_busy, 0);
    drive_idle();
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    tbl[0] = '{9,    0, 0, 0, -1, 0, 'h29B1};
    tbl[1] = '{9,    1, 0, 0, -1, 0, 'h29B1};
    tbl[2] = '{1024, 0, 1, 1, -1, 0, -1};
    tbl[3] = '{16,   0, 0, 2,  9, 1, -1};
    tbl[4] = '{1,    1, 0, 2, -1, 0, -1};
    tbl[5] = '{40,   2, 2, 2, -1, 0, -1};

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx_val", o_tx_val, 0);
    check("reset_tx_data", o_tx_data, 0);
    check("reset_busy", o_busy, 0);
    check("reset_err", o_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      run_frame($sformatf("vec%0d", t), tbl[t], -1);
      drive_idle();
      @(posedge clk); #1;
    end

    for (int r = 0; r < 6; r++) begin
      rv = '{0, 2, 2, 2, -1, 0, -1};
      rv.len = $urandom_range(1, 40);
      run_frame($sformatf("rand%0d", r), rv, -1);
      drive_idle();
      @(posedge clk); #1;
    end

    run_drain("drain_len0", 0, 16);
    @(posedge clk); #1;
    run_drain("drain_len1025", 1025, 5);
    @(posedge clk); #1;

    rv = '{16, 0, 0, 2, -1, 0, -1};
    run_frame("abort", rv, 5);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    run_frame("after_rst", tbl[0], -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_tx_framer.md
# pcs_tx_framer

PCS transmit framer sitting directly downstream of the FIFO-to-PCS interface. It consumes the byte-wide ARI frame stream (val/sof/eof/data with a single-cycle ack) and the per-frame length. It emits a framed byte stream toward the UART/VLC transmitter: preamble, SFD, 16-bit length, payload, CRC-16. Output uses a valid/ready handshake, so line back-pressure propagates to the FIFO through the withheld ack.

## Interface
- P_PREAMBLE_LEN, 4: number of 0x55 preamble bytes (1..15).
- P_GAP_LEN, 8: idle cycles enforced after the last CRC byte is accepted (0..255).
- P_MAX_LEN, 1024: largest legal payload length in bytes.
- i_clk  in  1  sole clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_ari_val  in  1  upstream byte valid.
- i_ari_sof  in  1  first byte of frame; qualified by i_ari_val.
- i_ari_eof  in  1  last-byte marker (checked only, not used for counting).
- i_ari_be  in  2  reserved, ignored.
- i_ari_data  in  8  payload byte.
- o_ari_ack  out  1  single-cycle pulse: current i_ari_data consumed.
- i_ari_frame_len  in  15  payload length in bytes.
- i_ari_frame_len_val  in  1  i_ari_frame_len is valid.
- o_tx_data  out  8  framed byte.
- o_tx_val  out  1  o_tx_data valid; held until i_tx_rdy.
- i_tx_rdy  in  1  downstream accepts byte when high with o_tx_val.
- o_busy  out  1  state != IDLE.
- o_frame_done  out  1  pulse when the CRC_LO byte is accepted.
- o_err  out  1  pulse on length or eof protocol error.

## Operation
- Frame on the wire: P_PREAMBLE_LEN × 0x55, 0xD5, LEN[15:8], LEN[7:0] (LEN = {1'b0, len}), payload, CRC[15:8], CRC[7:0].
- CRC: CRC-16/CCITT-FALSE (poly 0x1021, init 0xFFFF, no reflection, no xorout). Covers payload bytes only. Updated when a payload byte is loaded into the output register.
- One-byte output register, `slot`. A byte loads when `free` = !o_tx_val || i_tx_rdy.
- States:
  - IDLE: load len and go to PREAMBLE when i_ari_val && i_ari_sof && i_ari_frame_len_val.
  - PREAMBLE.
  - SFD.
  - LEN_HI.
  - LEN_LO.
  - PAYLOAD.
  - CRC_HI.
  - CRC_LO.
  - GAP: counts P_GAP_LEN cycles, then returns to IDLE (skipped if 0).
- Each non-GAP state advances when its byte loads into `slot`. PREAMBLE advances after P_PREAMBLE_LEN loads.
- PAYLOAD: a byte is taken when i_ari_val && free. That cycle: load slot, update CRC, pulse o_ari_ack, increment the payload counter. Exit to CRC_HI when the count reaches len.
- o_ari_ack is never asserted outside PAYLOAD. The sof byte itself is not acked in IDLE; it is acked as the first PAYLOAD byte.
- Length error: len == 0 or len > P_MAX_LEN at the sof cycle.
  - o_err pulses and the frame is dropped.
  - The block enters DRAIN: it acks every i_ari_val cycle, discarding data, until an ack coincides with i_ari_eof, then goes to IDLE.
  - Nothing is transmitted for a dropped frame.
- Eof check: o_err pulses if i_ari_eof is high on an acked byte other than the last, or low on the last. Transmission still completes with len bytes.
- i_ari_sof while busy is ignored (no error).
- Reset (asynchronous, any time):
  - State goes to IDLE; slot and counters clear; CRC resets to 0xFFFF.
  - All outputs are 0: o_tx_val, o_tx_data = 0x00, o_ari_ack, o_busy, o_frame_done, o_err.
  - A partially sent frame is abandoned; no tail is emitted.

## Timing
- sof+val+len_val sampled high at cycle t → o_tx_val=1 with 0x55 at t+1.
- With i_tx_rdy held high, one byte per cycle. The first payload ack is in the cycle LEN_LO is accepted.
- Continuous payload: one ack per cycle while i_ari_val && free. Upstream presents the next byte the cycle after ack.
- The ack is combinational from i_ari_val and i_tx_rdy. It must be a one-cycle pulse per byte and never asserted while i_ari_val=0.
- i_tx_rdy low: o_tx_val and o_tx_data hold stable, no ack is issued, and CRC does not change.
- o_frame_done is coincident with the CRC_LO handshake. The next sof is accepted no earlier than P_GAP_LEN+1 cycles later.

## Structure
- Package pcs_pkg holds:
  - the state enum;
  - PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5;
  - CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF;
  - function crc16_ccitt_byte(crc, data), a parallel 8-bit update.
- One sub-module, pcs_tx_out_reg: the one-byte valid/ready output slot, exposing `free`.

## Test plan
- len=9, payload 0x31..0x39, rdy=1, P_PREAMBLE_LEN=4 → 55 55 55 55 D5 00 09 31..39 29 B1, then o_frame_done, and exactly 9 acks.
- Same frame with i_tx_rdy toggling 1,0,0,1 repeatedly → identical byte sequence, o_tx_data stable while stalled, ack count 9, no ack while rdy=0.
- len=1024, bytes 0x00..0xFF repeating, upstream val gapped every 3rd cycle → 1024 acks, LEN bytes 04 00, CRC matches the model.
- len=0 with sof, then 16 val bytes with eof on the 16th → o_err pulses once, 16 acks, o_tx_val stays 0, back to IDLE.
- len=16 with eof on byte 10 → o_err pulse at byte 10, full 16-byte frame still sent.
- Assert i_rst mid-payload (byte 5 of 16) → all outputs 0 next edge. A new len=9 frame afterwards yields the clean first-scenario sequence.
